// File: rtl/whack_pkg.sv
// Shared state encoding, LFSR constants and default parameters for the
// whack-a-mole round controller and its mole selector.
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    UP,
    HIT,
    MISS,
    OVER
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Feedback taps 8,6,5,4 (x^8 + x^6 + x^5 + x^4 + 1), bit 7 is tap 8.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int DEF_NUM_MOLES      = 4;
  localparam int DEF_START_INTERVAL = 5;
  localparam int DEF_MIN_INTERVAL   = 1;
  localparam int DEF_LIVES          = 3;
  localparam int DEF_SCORE_W        = 8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit LFSR that proposes the next mole index and remembers
// the last one chosen, so the same mole never lights twice in a row.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter int NUM_MOLES = DEF_NUM_MOLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  output logic [$clog2(NUM_MOLES)-1:0] next_idx
);

  localparam int IDX_W = $clog2(NUM_MOLES);

  logic [7:0]       lfsr;
  logic [IDX_W-1:0] prev_idx;
  logic [IDX_W-1:0] cand;

  // A repeat of the previous mole is bumped to its neighbour, wrapping.
  always_comb begin
    cand     = lfsr[IDX_W-1:0];
    next_idx = (cand == prev_idx) ? cand + IDX_W'(1) : cand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      prev_idx <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (load) begin
        prev_idx <= next_idx;
      end
    end
  end

endmodule

// File: rtl/round_controller.sv
// Whack-a-mole round FSM: lights moles, scores hits, counts misses.
// Build option: define ROUND_SPEEDUP_EN to shorten the interval every 4th hit.
module round_controller
  import whack_pkg::*;
#(
  parameter int NUM_MOLES      = DEF_NUM_MOLES,
  parameter int START_INTERVAL = DEF_START_INTERVAL,
  parameter int MIN_INTERVAL   = DEF_MIN_INTERVAL,
  parameter int LIVES          = DEF_LIVES,
  parameter int SCORE_W        = DEF_SCORE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] whack,
  input  logic                 timeout,
  output logic                 timer_rst,
  output logic [2:0]           timer_interval,
  output logic                 timer_dir,
  output logic [NUM_MOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           lives,
  output logic                 game_over
);

  localparam int IDX_W = $clog2(NUM_MOLES);
  localparam logic [2:0] START_I =
    3'((START_INTERVAL < MIN_INTERVAL) ? MIN_INTERVAL : START_INTERVAL);
  localparam logic [2:0] LIVES_I = 3'(LIVES);

  state_t             state;
  logic [IDX_W-1:0]   next_idx;
  logic               whack_hit;
  logic               whack_any;
  logic [SCORE_W-1:0] score_inc;
  logic [2:0]         next_interval;

  assign timer_dir = 1'b0;

  mole_lfsr #(
    .NUM_MOLES(NUM_MOLES)
  ) u_mole_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ARM),
    .next_idx(next_idx)
  );

  // A saturated score ends in ...11, so it can never trigger a speed-up.
  always_comb begin
    whack_hit     = |(whack & mole);
    whack_any     = |whack;
    score_inc     = (&score) ? score : score + SCORE_W'(1);
    next_interval = timer_interval;
`ifdef ROUND_SPEEDUP_EN
    if ((score_inc[1:0] == 2'b00) && (timer_interval > 3'(MIN_INTERVAL))) begin
      next_interval = timer_interval - 3'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mole           <= '0;
      score          <= '0;
      lives          <= LIVES_I;
      timer_rst      <= 1'b0;
      timer_interval <= START_I;
      game_over      <= 1'b0;
    end else begin
      timer_rst <= 1'b0;
      unique case (state)
        IDLE, OVER: begin
          if (start) begin
            state          <= ARM;
            score          <= '0;
            lives          <= LIVES_I;
            timer_interval <= START_I;
            timer_rst      <= 1'b1;
            game_over      <= 1'b0;
          end
        end
        ARM: begin
          state <= UP;
          mole  <= NUM_MOLES'(1) << next_idx;
        end
        // A correct whack outranks a wrong whack or a timeout in the same cycle.
        UP: begin
          if (whack_hit) begin
            state <= HIT;
            mole  <= '0;
          end else if (whack_any || timeout) begin
            state <= MISS;
            mole  <= '0;
          end
        end
        HIT: begin
          score          <= score_inc;
          timer_interval <= next_interval;
          timer_rst      <= 1'b1;
          state          <= ARM;
        end
        MISS: begin
          lives <= lives - 3'd1;
          if (lives == 3'd1) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            state     <= ARM;
            timer_rst <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          mole  <= '0;
        end
      endcase
    end
  end

endmodule
